// File: rtl/alu_seq.sv
// alu_seq: multi-word ALU sequencer.
// Walks an N-word operation LSW-first. For each word it reads the LHS and RHS
// from operand memory, presents them to the ALU, and writes the result back.
// Optional build macro ALU_SEQ_ABORT_EN adds an abort input and an aborted flag.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; request fields latched on accept
// S_RD_L  | read LHS word i
// S_RD_R  | read RHS word i; capture LHS data into alu_lhs
// S_LATCH | capture RHS data into alu_rhs; select ALU op for word i
// S_WR    | ALU driven, result written to dst+i, flags accumulated
// S_DONE  | one-cycle done pulse; ALU op cleared
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int AW    = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ALU_SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    input  logic             start,
    input  logic [3:0]       op_first,
    input  logic [3:0]       op_next,
    input  logic [AW-1:0]    lhs_base,
    input  logic [AW-1:0]    rhs_base,
    input  logic [AW-1:0]    dst_base,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             res_zero,
    output logic             res_carry,
    output logic             res_sign,
    output logic             res_ovf,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_wr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [WIDTH-1:0] alu_lhs,
    output logic [WIDTH-1:0] alu_rhs,
    output logic [3:0]       alu_operation,
    output logic             alu_assert_n,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_sign,
    input  logic             alu_ovf
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_L, S_RD_R, S_LATCH, S_WR, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [AW-1:0]    lhs_base_q, lhs_base_d;
    logic [AW-1:0]    rhs_base_q, rhs_base_d;
    logic [AW-1:0]    dst_base_q, dst_base_d;
    logic [3:0]       op_first_q, op_first_d;
    logic [3:0]       op_next_q, op_next_d;
    logic [WIDTH-1:0] alu_lhs_q, alu_lhs_d;
    logic [WIDTH-1:0] alu_rhs_q, alu_rhs_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             res_zero_q, res_zero_d;
    logic             res_carry_q, res_carry_d;
    logic             res_sign_q, res_sign_d;
    logic             res_ovf_q, res_ovf_d;
    logic             abort_req;

`ifdef ALU_SEQ_ABORT_EN
    logic aborted_q, aborted_d;
    assign abort_req = abort;
    assign aborted   = aborted_q;

    // Aborted flag: cleared on accept, set when an abort cuts the op short.
    always_comb begin
        aborted_d = aborted_q;
        if (state_q == S_IDLE && start) begin
            aborted_d = 1'b0;
        end else if (abort_req && (state_q == S_RD_L || state_q == S_RD_R ||
                                   state_q == S_LATCH || state_q == S_WR)) begin
            aborted_d = 1'b1;
        end
    end

    // Aborted flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) aborted_q <= 1'b0;
        else        aborted_q <= aborted_d;
    end
`else
    assign abort_req = 1'b0;
`endif

    assign alu_lhs       = alu_lhs_q;
    assign alu_rhs       = alu_rhs_q;
    assign alu_operation = alu_op_q;
    assign res_zero      = res_zero_q;
    assign res_carry     = res_carry_q;
    assign res_sign      = res_sign_q;
    assign res_ovf       = res_ovf_q;

    // Next-state, datapath updates and memory/ALU strobes decoded from state.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        lhs_base_d   = lhs_base_q;
        rhs_base_d   = rhs_base_q;
        dst_base_d   = dst_base_q;
        op_first_d   = op_first_q;
        op_next_d    = op_next_q;
        alu_lhs_d    = alu_lhs_q;
        alu_rhs_d    = alu_rhs_q;
        alu_op_d     = alu_op_q;
        res_zero_d   = res_zero_q;
        res_carry_d  = res_carry_q;
        res_sign_d   = res_sign_q;
        res_ovf_d    = res_ovf_q;
        mem_addr     = '0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_wdata    = '0;
        alu_assert_n = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = len;
                    lhs_base_d = lhs_base;
                    rhs_base_d = rhs_base;
                    dst_base_d = dst_base;
                    op_first_d = op_first;
                    op_next_d  = op_next;
                    idx_d      = '0;
                    // A zero-length op leaves the previous flags untouched.
                    if (len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        res_zero_d = 1'b1;
                        state_d    = S_RD_L;
                    end
                end
            end
            S_RD_L: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = lhs_base_q + AW'(idx_q);
                state_d  = abort_req ? S_DONE : S_RD_R;
            end
            S_RD_R: begin
                busy      = 1'b1;
                mem_rd    = 1'b1;
                mem_addr  = rhs_base_q + AW'(idx_q);
                alu_lhs_d = mem_rdata;
                state_d   = abort_req ? S_DONE : S_LATCH;
            end
            S_LATCH: begin
                busy      = 1'b1;
                alu_rhs_d = mem_rdata;
                alu_op_d  = (idx_q == '0) ? op_first_q : op_next_q;
                state_d   = abort_req ? S_DONE : S_WR;
            end
            S_WR: begin
                busy         = 1'b1;
                alu_assert_n = 1'b0;
                mem_wr       = 1'b1;
                mem_addr     = dst_base_q + AW'(idx_q);
                mem_wdata    = alu_result;
                res_zero_d   = res_zero_q & alu_zero;
                res_carry_d  = alu_carry;
                res_sign_d   = alu_sign;
                res_ovf_d    = alu_ovf;
                idx_d        = idx_q + LEN_W'(1);
                // The word is still written on abort; only the loop is cut.
                state_d      = (abort_req || idx_d == len_q) ? S_DONE : S_RD_L;
            end
            S_DONE: begin
                done     = 1'b1;
                alu_op_d = '0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            lhs_base_q  <= '0;
            rhs_base_q  <= '0;
            dst_base_q  <= '0;
            op_first_q  <= '0;
            op_next_q   <= '0;
            alu_lhs_q   <= '0;
            alu_rhs_q   <= '0;
            alu_op_q    <= '0;
            res_zero_q  <= 1'b1;
            res_carry_q <= 1'b0;
            res_sign_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            lhs_base_q  <= lhs_base_d;
            rhs_base_q  <= rhs_base_d;
            dst_base_q  <= dst_base_d;
            op_first_q  <= op_first_d;
            op_next_q   <= op_next_d;
            alu_lhs_q   <= alu_lhs_d;
            alu_rhs_q   <= alu_rhs_d;
            alu_op_q    <= alu_op_d;
            res_zero_q  <= res_zero_d;
            res_carry_q <= res_carry_d;
            res_sign_q  <= res_sign_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: memory + 8-bit ALU models, table vectors,
// hand-written corner sequences and random ops against a big-integer model.
module tb_alu_seq;

    localparam logic [3:0] OP_ADD = 4'd1, OP_ADC = 4'd2, OP_SUB = 4'd3,
                           OP_SBC = 4'd4, OP_AND = 4'd5, OP_XOR = 4'd6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op_first = '0, op_next = '0;
    logic [7:0] lhs_base = '0, rhs_base = '0, dst_base = '0;
    logic [3:0] len = '0;
    logic       busy, done, res_zero, res_carry, res_sign, res_ovf;
    logic [7:0] mem_addr, mem_rdata, mem_wdata, alu_lhs, alu_rhs, alu_result;
    logic       mem_rd, mem_wr, alu_assert_n;
    logic [3:0] alu_operation;
    logic       alu_zero, alu_carry, alu_sign, alu_ovf;
`ifdef ALU_SEQ_ABORT_EN
    logic       abort = 1'b0;
    logic       aborted;
`endif

    alu_seq dut (
        .clk(clk), .rst_n(rst_n),
`ifdef ALU_SEQ_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .start(start), .op_first(op_first), .op_next(op_next),
        .lhs_base(lhs_base), .rhs_base(rhs_base), .dst_base(dst_base), .len(len),
        .busy(busy), .done(done),
        .res_zero(res_zero), .res_carry(res_carry), .res_sign(res_sign), .res_ovf(res_ovf),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_operation(alu_operation),
        .alu_assert_n(alu_assert_n), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_ovf(alu_ovf)
    );

    always #5 clk = ~clk;

    // ---------------- memory model and activity monitors ----------------
    logic [7:0] mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_a = '0, tb_d = '0;
    logic [7:0] rd_log [8192];
    int rd_total = 0, wr_total = 0, done_total = 0, sync_bad = 0;

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem[mem_addr];
            rd_log[rd_total % 8192] <= mem_addr;
            rd_total <= rd_total + 1;
        end
        if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
            wr_total <= wr_total + 1;
        end else if (tb_we) begin
            mem[tb_a] <= tb_d;
        end
        if (done) done_total <= done_total + 1;
        if ((alu_assert_n == 1'b0) != mem_wr) sync_bad <= sync_bad + 1;
    end

    // ---------------- 8-bit ALU model with carry chain ----------------
    logic       alu_cq = 1'b0;
    logic [8:0] sum9;
    always @(posedge clk) if (!alu_assert_n) alu_cq <= alu_carry;

    always_comb begin
        sum9      = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (alu_operation)
            OP_ADD: sum9 = {1'b0, alu_lhs} + {1'b0, alu_rhs};
            OP_ADC: sum9 = {1'b0, alu_lhs} + {1'b0, alu_rhs} + {8'd0, alu_cq};
            OP_SUB: sum9 = {1'b0, alu_lhs} + {1'b0, ~alu_rhs} + 9'd1;
            OP_SBC: sum9 = {1'b0, alu_lhs} + {1'b0, ~alu_rhs} + {8'd0, alu_cq};
            OP_AND: sum9 = {1'b0, alu_lhs & alu_rhs};
            OP_XOR: sum9 = {1'b0, alu_lhs ^ alu_rhs};
            default: sum9 = '0;
        endcase
        if (alu_operation == OP_ADD || alu_operation == OP_ADC) begin
            alu_carry = sum9[8];
            alu_ovf   = (alu_lhs[7] == alu_rhs[7]) && (sum9[7] != alu_lhs[7]);
        end else if (alu_operation == OP_SUB || alu_operation == OP_SBC) begin
            alu_carry = sum9[8];
            alu_ovf   = (alu_lhs[7] != alu_rhs[7]) && (sum9[7] != alu_lhs[7]);
        end
        alu_result = sum9[7:0];
        alu_zero   = (sum9[7:0] == 8'd0);
        alu_sign   = sum9[7];
    end

    // ---------------- checking helpers ----------------
    int total = 0, bad = 0;
    logic ez = 1'b1, ec = 1'b0, es = 1'b0, ev = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_a = a; tb_d = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic start_op(input logic [3:0] of, input logic [3:0] on, input logic [7:0] lb,
                            input logic [7:0] rb, input logic [7:0] db, input int ln);
        @(negedge clk);
        op_first = of; op_next = on; lhs_base = lb; rhs_base = rb; dst_base = db;
        len = 4'(ln); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the cycle index (start accept = 0) at which done is seen.
    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Big-integer reference: kind 0=add,1=sub,2=and,3=xor over len bytes.
    function automatic void model(input int kind, input logic [127:0] l, input logic [127:0] r,
                                  input int ln, output logic [127:0] res,
                                  output logic z, output logic c, output logic s, output logic v);
        logic [127:0] mask, full;
        mask = (128'd1 << (8 * ln)) - 128'd1;
        c = 1'b0; v = 1'b0;
        case (kind)
            0: begin
                full = l + r;
                res  = full & mask;
                c    = full[8 * ln];
                v    = (l[8*ln-1] == r[8*ln-1]) && (res[8*ln-1] != l[8*ln-1]);
            end
            1: begin
                res = (l - r) & mask;
                c   = (l >= r);
                v   = (l[8*ln-1] != r[8*ln-1]) && (res[8*ln-1] != l[8*ln-1]);
            end
            2: res = l & r;
            default: res = l ^ r;
        endcase
        z = (res == 128'd0);
        s = res[8*ln-1];
    endfunction

    task automatic run_op(input string nm, input logic [3:0] of, input logic [3:0] on,
                          input logic [7:0] lb, input logic [7:0] rb, input logic [7:0] db,
                          input int ln, input logic [127:0] l, input logic [127:0] r,
                          input logic [127:0] er, input logic z, input logic c,
                          input logic s, input logic v);
        int w0, r0, cyc;
        logic [127:0] got;
        for (int i = 0; i < ln; i++) begin
            poke(lb + 8'(i), l[8*i +: 8]);
            poke(rb + 8'(i), r[8*i +: 8]);
        end
        w0 = wr_total; r0 = rd_total;
        start_op(of, on, lb, rb, db, ln);
        wait_done(1, cyc);
        chk({nm, "_cycle"}, 128'(cyc), 128'(4 * ln + 1));
        @(negedge clk);
        chk({nm, "_writes"}, 128'(wr_total - w0), 128'(ln));
        chk({nm, "_reads"}, 128'(rd_total - r0), 128'(2 * ln));
        got = '0;
        for (int i = 0; i < ln; i++) got[8*i +: 8] = mem[db + 8'(i)];
        if (ln > 0) chk({nm, "_result"}, got, er);
        if (ln > 0) begin
            ez = z; ec = c; es = s; ev = v;
        end
        chk({nm, "_flags"}, 128'({res_zero, res_carry, res_sign, res_ovf}), 128'({ez, ec, es, ev}));
    endtask

    typedef struct {
        logic [3:0]  of, on;
        logic [31:0] l, r;
        int          ln;
        logic [31:0] res;
        logic        z, c, s, v;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int cyc, w0, r0, d0;
        logic [127:0] l, r, er, mask;
        logic z, c, s, v;
        int kind, ln;
        logic [7:0] lb;
        logic [3:0] ops_f [4];
        logic [3:0] ops_n [4];

        tbl[0] = '{OP_ADD, OP_ADC, 32'h00FF, 32'h0001, 2, 32'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{OP_ADD, OP_ADC, 32'h8000, 32'h8000, 2, 32'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{OP_SUB, OP_SBC, 32'h0100, 32'h0001, 2, 32'h00FF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{OP_SUB, OP_SBC, 32'h00, 32'h01, 1, 32'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{OP_ADD, OP_ADC, 32'h7FFFFFFF, 32'h1, 4, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{OP_XOR, OP_XOR, 32'h123456, 32'h123456, 3, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{OP_AND, OP_AND, 32'hF0, 32'h3C, 1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        ops_f[0] = OP_ADD; ops_n[0] = OP_ADC;
        ops_f[1] = OP_SUB; ops_n[1] = OP_SBC;
        ops_f[2] = OP_AND; ops_n[2] = OP_AND;
        ops_f[3] = OP_XOR; ops_n[3] = OP_XOR;

        // Reset state
        #12;
        chk("reset_ctrl", 128'({busy, done, mem_rd, mem_wr, alu_assert_n}), 128'(5'b00001));
        chk("reset_flags", 128'({res_zero, res_carry, res_sign, res_ovf}), 128'(4'b1000));
        chk("reset_alu", 128'({alu_operation, alu_lhs, alu_rhs, mem_addr, mem_wdata}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors
        foreach (tbl[k]) begin
            run_op($sformatf("vec%0d", k), tbl[k].of, tbl[k].on, 8'h10, 8'h20, 8'h30,
                   tbl[k].ln, 128'(tbl[k].l), 128'(tbl[k].r), 128'(tbl[k].res),
                   tbl[k].z, tbl[k].c, tbl[k].s, tbl[k].v);
        end

        // len=0: immediate done, no memory traffic, flags unchanged
        run_op("len0", OP_ADD, OP_ADC, 8'h10, 8'h20, 8'h30, 0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // start pulses while busy are ignored
        poke(8'h10, 8'hFF); poke(8'h11, 8'h00); poke(8'h20, 8'h01); poke(8'h21, 8'h00);
        w0 = wr_total; d0 = done_total;
        start_op(OP_ADD, OP_ADC, 8'h10, 8'h20, 8'h30, 2);
        start = 1'b1; len = 4'd5;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(3, cyc);
        chk("busy_start_cycle", 128'(cyc), 128'(9));
        chk("busy_start_busy_at_done", 128'(busy), 128'(0));
        repeat (6) @(negedge clk);
        chk("busy_start_dones", 128'(done_total - d0), 128'(1));
        chk("busy_start_writes", 128'(wr_total - w0), 128'(2));
        ez = 1'b0; ec = 1'b0; es = 1'b0; ev = 1'b0;

        // Address wrap at 0xFF with dst aliasing lhs
        poke(8'hFF, 8'hFF); poke(8'h00, 8'h01); poke(8'h40, 8'h01); poke(8'h41, 8'h00);
        r0 = rd_total;
        start_op(OP_ADD, OP_ADC, 8'hFF, 8'h40, 8'hFF, 2);
        wait_done(1, cyc);
        @(negedge clk);
        chk("wrap_cycle", 128'(cyc), 128'(9));
        chk("wrap_rd_addrs", 128'({rd_log[r0 % 8192], rd_log[(r0 + 1) % 8192],
                                   rd_log[(r0 + 2) % 8192], rd_log[(r0 + 3) % 8192]}),
            128'(32'hFF_40_00_41));
        chk("wrap_alias_sum", 128'({mem[8'h00], mem[8'hFF]}), 128'(16'h0200));
        chk("wrap_flags", 128'({res_zero, res_carry}), 128'(2'b00));

        // Reset asserted during the write of word 1
        poke(8'h10, 8'hFF); poke(8'h11, 8'h00); poke(8'h20, 8'h01); poke(8'h21, 8'h00);
        poke(8'h30, 8'h5A); poke(8'h31, 8'h5A);
        start_op(OP_ADD, OP_ADC, 8'h10, 8'h20, 8'h30, 2);
        repeat (7) @(negedge clk);
        chk("rst_mid_pre_wr", 128'({mem_wr, mem_addr}), 128'({1'b1, 8'h31}));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", 128'({mem_wr, busy, alu_assert_n, mem_rd}), 128'(4'b0010));
        chk("rst_mid_flags", 128'({res_zero, res_carry, res_sign, res_ovf}), 128'(4'b1000));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_partial", 128'({mem[8'h31], mem[8'h30]}), 128'(16'h5A00));
        ez = 1'b1; ec = 1'b0; es = 1'b0; ev = 1'b0;
        run_op("after_rst", tbl[1].of, tbl[1].on, 8'h10, 8'h20, 8'h30, tbl[1].ln,
               128'(tbl[1].l), 128'(tbl[1].r), 128'(tbl[1].res),
               tbl[1].z, tbl[1].c, tbl[1].s, tbl[1].v);

`ifdef ALU_SEQ_ABORT_EN
        // Abort in RD_R of word 2 of a 4-word op
        w0 = wr_total;
        start_op(OP_ADD, OP_ADC, 8'h10, 8'h20, 8'h30, 4);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", 128'({done, aborted}), 128'(2'b11));
        chk("abort_writes", 128'(wr_total - w0), 128'(2));
        @(negedge clk);
        chk("abort_idle", 128'({busy, done}), 128'(2'b00));
        ez = res_zero; ec = res_carry; es = res_sign; ev = res_ovf;
        run_op("abort_clear", OP_AND, OP_AND, 8'h10, 8'h20, 8'h30, 1, 128'hF0, 128'h3C,
               128'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_cleared", 128'(aborted), 128'(0));
`endif

        // Random ops against the big-integer reference
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 3));
            ln   = int'($urandom_range(0, 15));
            lb   = 8'($urandom);
            mask = (128'd1 << (8 * ln)) - 128'd1;
            l = {$urandom, $urandom, $urandom, $urandom} & mask;
            r = {$urandom, $urandom, $urandom, $urandom} & mask;
            if (ln > 0) model(kind, l, r, ln, er, z, c, s, v);
            else begin
                er = '0; z = ez; c = ec; s = es; v = ev;
            end
            run_op($sformatf("rand%0d", n), ops_f[kind], ops_n[kind], lb, lb + 8'h40,
                   lb + 8'h80, ln, l, r, er, z, c, s, v);
        end

        chk("alu_drive_only_in_wr", 128'(sync_bad), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
